counter7_arbiter: RTL and testbench
===================================

COUNTER7_ARBITER -- requirements
Module: counter7_arbiter

Interface
REQ-001 The block SHALL use one clock and one reset; the reset is asynchronous and active-low.
REQ-002 Cp  in  1  clock; all state SHALL change on the rising edge only.
REQ-003 R  in  1  reset; asynchronous, active-low; R=0 clears all state immediately.
REQ-004 req0, req1  in  1 each  requests for the shared mod-7 counter; level, held until the matching grant is seen.
REQ-005 len0, len1  in  3 each  terminal count per requester; sampled only at grant.
REQ-006 hold  in  1  pauses counting while high.
REQ-007 abort  in  1  terminates the current grant without a done pulse.
REQ-008 gnt0, gnt1  out  1 each  grant; at most one high; high for the whole RUN state.
REQ-009 done0, done1  out  1 each  one-cycle completion pulse to the served requester.
REQ-010 y  out  3  counter value, binary, y[0]=LSB, range 0..6.
REQ-011 busy  out  1  high in RUN and DONE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-013 IDLE: if neither request is high, stay IDLE; y=0, gnt0=gnt1=0.
REQ-014 IDLE with a request: on the next edge enter RUN, raise the selected gnt, set y=0, latch target from the selected len.
REQ-015 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; after reset req0 has priority.
REQ-016 Target mapping: len=0 -> 1; len=7 -> 6; len 1..6 -> unchanged.
REQ-017 RUN, abort=1: next edge -> IDLE, gnt low, y=0, no done pulse; abort takes precedence over hold and over terminal count.
REQ-018 RUN, abort=0, hold=1: y and state SHALL hold.
REQ-019 RUN, abort=0, hold=0, y!=target: y increments by 1.
REQ-020 RUN, abort=0, hold=0, y==target: next edge -> DONE; y holds at target.
REQ-021 Mod-7 wrap: y SHALL never leave 0..6; an increment from 6 SHALL produce 0 (unreachable by construction).
REQ-022 DONE: the served done output SHALL be 1 for exactly this one cycle; gnt low; next edge -> IDLE with y=0.
REQ-023 abort and hold SHALL be ignored in IDLE and DONE.
REQ-024 Latency, no hold: request sampled at edge k -> gnt high after k; y==target after edge k+target; done high after edge k+target+1; IDLE after edge k+target+2.
REQ-025 A new grant SHALL NOT be issued from DONE; there is at least one IDLE cycle between grants.
REQ-026 A requester dropping its request during RUN SHALL NOT affect the run; len changes during RUN SHALL be ignored.
REQ-027 The last-served pointer SHALL update on entry to DONE and on abort, pointing to the requester just served.
REQ-028 Outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-029 With R=0: state=IDLE, y=0, gnt0=gnt1=0, done0=done1=0, busy=0, last-served=req1, so req0 wins the first tie.
REQ-030 Reset asserted mid-RUN or mid-DONE SHALL clear all state immediately, with no done pulse; on release the block starts in IDLE.

Verification
REQ-031 Reset release; req0=1, len0=3 -> gnt0 high after next edge; y=0,1,2,3 on consecutive cycles; then done0 one cycle; then IDLE with y=0.
REQ-032 req0=req1=1 continuously, len=2 -> grant order gnt0, gnt1, gnt0, with exactly one IDLE cycle between runs.
REQ-033 req1=1, len1=5; hold=1 for 4 cycles at y=2 -> y stays 2 for 4 cycles; done1 arrives 4 cycles later than the no-hold case.
REQ-034 len0=0 -> y=0,1 then done0; len0=7 -> y reaches 6 then done0; y never shows 7.
REQ-035 Abort at y=3 with hold=1 simultaneously -> IDLE next edge, no done pulse; the following tie goes to the other requester.
REQ-036 R pulled low at y=4 between clock edges -> all outputs 0 immediately; req0=1 after release restarts with y=0.

Source files
------------

// File: rtl/counter7_arbiter.sv
// counter7_arbiter
//   Two requesters share a single mod-7 up-counter. A granted requester's
//   counter runs from 0 up to its terminal count and then gets a one-cycle
//   done pulse. Ties between the requesters are broken round-robin.
//
// Ports
//   Cp          clock, rising edge
//   R           asynchronous active-low reset
//   req0, req1  level requests, held until the matching grant is seen
//   len0, len1  terminal count per requester, sampled only at grant
//   hold        freezes counting while a run is in progress
//   abort       ends the current run at once, with no done pulse
//   gnt0, gnt1  grant, high for the whole run (at most one high)
//   done0, done1 one-cycle completion pulse to the requester just served
//   y           counter value, 0..6
//   busy        high while running or signalling done
module counter7_arbiter (
    input  logic       Cp,
    input  logic       R,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] len0,
    input  logic [2:0] len1,
    input  logic       hold,
    input  logic       abort,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [2:0] y,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [2:0] y_reg, y_next;
    logic [2:0] target_reg, target_next;
    logic       owner_reg, owner_next;   // requester holding the counter
    logic       last_reg, last_next;     // requester served most recently
    logic       pick;

    // Terminal counts outside 1..6 are clamped into the counter's range.
    function automatic logic [2:0] map_len(input logic [2:0] len);
        logic [2:0] t;
        case (len)
            3'd0:    t = 3'd1;
            3'd7:    t = 3'd6;
            default: t = len;
        endcase
        return t;
    endfunction

    always_ff @(posedge Cp or negedge R) begin
        if (!R) begin
            state_reg  <= IDLE;
            y_reg      <= 3'd0;
            target_reg <= 3'd1;
            owner_reg  <= 1'b0;
            // Pretend req1 was served last so req0 wins the first tie.
            last_reg   <= 1'b1;
        end else begin
            state_reg  <= state_next;
            y_reg      <= y_next;
            target_reg <= target_next;
            owner_reg  <= owner_next;
            last_reg   <= last_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        y_next      = y_reg;
        target_next = target_reg;
        owner_next  = owner_reg;
        last_next   = last_reg;
        pick        = 1'b0;

        case (state_reg)
            IDLE: begin
                y_next = 3'd0;
                if (req0 || req1) begin
                    // On a tie the requester not served last goes next.
                    pick        = (req0 && req1) ? ~last_reg : req1;
                    owner_next  = pick;
                    target_next = map_len(pick ? len1 : len0);
                    state_next  = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                    y_next     = 3'd0;
                    last_next  = owner_reg;
                end else if (!hold) begin
                    if (y_reg != target_reg) begin
                        // Wrap keeps y inside 0..6 even though the target
                        // never lets the count reach past 6.
                        y_next = (y_reg == 3'd6) ? 3'd0 : y_reg + 3'd1;
                    end else begin
                        state_next = DONE;
                        last_next  = owner_reg;
                    end
                end
            end
            DONE: begin
                // Always pass through IDLE before the next grant.
                state_next = IDLE;
                y_next     = 3'd0;
            end
            default: begin
                state_next = IDLE;
                y_next     = 3'd0;
            end
        endcase
    end

    assign gnt0  = (state_reg == RUN)  && !owner_reg;
    assign gnt1  = (state_reg == RUN)  &&  owner_reg;
    assign done0 = (state_reg == DONE) && !owner_reg;
    assign done1 = (state_reg == DONE) &&  owner_reg;
    assign busy  = (state_reg == RUN) || (state_reg == DONE);
    assign y     = y_reg;

endmodule

// File: tb/tb_counter7_arbiter.sv
module tb_counter7_arbiter;

    logic       Cp, R;
    logic       req0, req1, hold, abort;
    logic [2:0] len0, len1;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [2:0] y;

    int n_checks = 0;
    int n_errors = 0;

    counter7_arbiter dut (
        .Cp(Cp), .R(R),
        .req0(req0), .req1(req1),
        .len0(len0), .len1(len1),
        .hold(hold), .abort(abort),
        .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1),
        .y(y), .busy(busy)
    );

    initial begin
        Cp = 1'b0;
        forever #5 Cp = ~Cp;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A run is described by who owns it, its clamped target and how far the
    // count has progressed; a finished run leaves a pending done pulse.
    logic       m_active, m_done, m_who, m_last;
    int         m_y, m_tgt;

    function automatic int clamp_len(input int len);
        if (len < 1) return 1;
        if (len > 6) return 6;
        return len;
    endfunction

    always @(posedge Cp or negedge R) begin
        if (!R) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_who    <= 1'b0;
            m_last   <= 1'b1;
            m_y      <= 0;
            m_tgt    <= 1;
        end else if (m_done) begin
            m_done <= 1'b0;
            m_y    <= 0;
        end else if (!m_active) begin
            m_y <= 0;
            if (req0 || req1) begin
                automatic logic w = (req0 && req1) ? (m_last ? 1'b0 : 1'b1)
                                                   : (req1 ? 1'b1 : 1'b0);
                m_active <= 1'b1;
                m_who    <= w;
                m_tgt    <= clamp_len(w ? int'(len1) : int'(len0));
            end
        end else if (abort) begin
            m_active <= 1'b0;
            m_y      <= 0;
            m_last   <= m_who;
        end else if (!hold) begin
            if (m_y < m_tgt) begin
                m_y <= m_y + 1;
            end else begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
                m_last   <= m_who;
            end
        end
    end

    always @(negedge Cp) begin
        chk("cyc_y",     int'(y),     m_y);
        chk("cyc_gnt0",  int'(gnt0),  int'(m_active && !m_who));
        chk("cyc_gnt1",  int'(gnt1),  int'(m_active &&  m_who));
        chk("cyc_done0", int'(done0), int'(m_done && !m_who));
        chk("cyc_done1", int'(done1), int'(m_done &&  m_who));
        chk("cyc_busy",  int'(busy),  int'(m_active || m_done));
        chk("cyc_y_range", int'(y <= 3'd6), 1);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge Cp);
        #2;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        chk(name, int'(busy), 0);
        tick();
    endtask

    task automatic do_reset();
        R = 1'b0;
        tick();
        tick();
        R = 1'b1;
    endtask

    initial begin
        int gcount;
        int ymax;
        int seen_done;
        R = 1'b0; req0 = 0; req1 = 0; hold = 0; abort = 0; len0 = 0; len1 = 0;
        #1;
        chk("rst_y", int'(y), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_outs", int'({gnt0, gnt1, done0, done1}), 0);
        do_reset();

        // Basic run, len0=3
        req0 = 1; len0 = 3;
        tick();
        chk("r1_gnt0", int'(gnt0), 1);
        chk("r1_y0", int'(y), 0);
        req0 = 0;
        tick(); chk("r1_y1", int'(y), 1);
        tick(); chk("r1_y2", int'(y), 2);
        tick(); chk("r1_y3", int'(y), 3);
        tick();
        chk("r1_done0", int'(done0), 1);
        chk("r1_gnt_off", int'(gnt0), 0);
        hold = 1; abort = 1;    // must be ignored in DONE
        tick();
        hold = 0; abort = 0;
        chk("r1_idle_busy", int'(busy), 0);
        chk("r1_idle_y", int'(y), 0);
        chk("r1_idle_done", int'(done0), 0);

        // Round-robin with both requesting, len=2, from a fresh reset
        do_reset();
        req0 = 1; req1 = 1; len0 = 2; len1 = 2;
        tick();  chk("rr_g1_gnt0", int'(gnt0), 1);
        tick(); tick(); tick();
        chk("rr_done0", int'(done0), 1);
        tick();  chk("rr_idle1", int'(busy), 0);
        tick();  chk("rr_g2_gnt1", int'(gnt1), 1);
        tick(); tick(); tick();
        chk("rr_done1", int'(done1), 1);
        tick();  chk("rr_idle2", int'(busy), 0);
        tick();  chk("rr_g3_gnt0", int'(gnt0), 1);
        req0 = 0; req1 = 0;
        wait_idle("rr_timeout");

        // Hold for 4 cycles at y=2, len1=5
        req1 = 1; len1 = 5;
        tick();
        chk("h_gnt1", int'(gnt1), 1);
        req1 = 0;
        gcount = 0;
        tick(); gcount++;
        tick(); gcount++;
        chk("h_y2", int'(y), 2);
        hold = 1;
        for (int i = 0; i < 4; i++) begin
            tick(); gcount++;
            chk("h_y_held", int'(y), 2);
        end
        hold = 0;
        while (!done1 && gcount < 20) begin
            tick(); gcount++;
        end
        chk("h_done_latency", gcount, 10);
        tick();

        // len0=0 clamps to 1
        req0 = 1; len0 = 0;
        tick(); chk("l0_y0", int'(y), 0);
        req0 = 0;
        tick(); chk("l0_y1", int'(y), 1);
        tick(); chk("l0_done0", int'(done0), 1);
        tick();

        // len0=7 clamps to 6; len change during RUN is ignored
        req0 = 1; len0 = 7;
        tick();
        req0 = 0; len0 = 1;
        ymax = 0; seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (int'(y) > ymax) ymax = int'(y);
            if (done0) seen_done = 1;
            tick();
        end
        chk("l7_ymax", ymax, 6);
        chk("l7_done_seen", seen_done, 1);

        // Abort at y=3 with hold, then tie goes to req1
        req0 = 1; len0 = 5;
        tick(); req0 = 0;
        tick(); tick(); tick();
        chk("ab_y3", int'(y), 3);
        abort = 1; hold = 1;
        tick();
        abort = 0; hold = 0;
        chk("ab_busy", int'(busy), 0);
        chk("ab_no_done", int'(done0), 0);
        chk("ab_y", int'(y), 0);
        req0 = 1; req1 = 1; len1 = 2;
        tick();
        chk("ab_tie_gnt1", int'(gnt1), 1);
        req0 = 0; req1 = 0;
        wait_idle("ab_timeout");

        // Asynchronous reset at y=4
        req0 = 1; len0 = 6;
        tick(); req0 = 0;
        tick(); tick(); tick(); tick();
        chk("ar_y4", int'(y), 4);
        #1 R = 1'b0;
        #1;
        chk("ar_y", int'(y), 0);
        chk("ar_outs", int'({gnt0, gnt1, done0, done1, busy}), 0);
        @(posedge Cp); #2;
        R = 1'b1;
        req0 = 1;
        tick();
        chk("ar_restart_gnt0", int'(gnt0), 1);
        chk("ar_restart_y", int'(y), 0);
        req0 = 0;
        wait_idle("ar_timeout");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
